vector_sweep_gen: RTL and testbench

VECTOR_SWEEP_GEN -- requirements
Module: vector_sweep_gen

---
 rtl/vsg_pkg.sv | 29 ++
 rtl/vsg_hold_timer.sv | 31 +++
 rtl/vector_sweep_gen.sv | 115 +++++++++++
 tb/tb_vector_sweep_gen.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vsg_pkg.sv
// Shared types and sizing for the vector sweep generator.
// Holds the sweep FSM encoding and the response slot insertion helper.
// No timing behaviour of its own.
package vsg_pkg;

    localparam int NUM_VECTORS = 8;
    localparam int VEC_W       = 3;
    localparam int RESP_W      = 16;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    // Two response bits per vector, vector n lives at bits [2n+1:2n].
    function automatic logic [RESP_W-1:0] resp_insert(
        input logic [RESP_W-1:0] r,
        input logic [VEC_W-1:0]  idx,
        input logic [1:0]        v
    );
        logic [RESP_W-1:0] t;
        t = r;
        t[{idx, 1'b0} +: 2] = v;
        return t;
    endfunction

endpackage

// File: rtl/vsg_hold_timer.sv
// Hold timer: counts DRIVE cycles 0..HOLD_CYCLES-1 and flags the last one.
// Latency: expire is combinational on the count, asserted in the final hold cycle.
// No backpressure: load wins over enable, count returns to 0 after expiry.
module vsg_hold_timer #(
    parameter int HOLD_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    assign expire = enable && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= expire ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/vector_sweep_gen.sv
// Sweeps 3-bit vectors 0..7 into a combinational stage and captures 2-bit responses.
// Latency: done pulses 8*(HOLD_CYCLES+1) cycles after start; optional VSG_CHECK_EN compares resp.
// No backpressure: start is only sampled in IDLE and never queued.
module vector_sweep_gen
    import vsg_pkg::*;
#(
    parameter int HOLD_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              in_1,
    output logic              in_2,
    output logic              in_3,
    input  logic              out_1,
    input  logic              out_2,
    output logic              busy,
    output logic              done,
    output logic [VEC_W-1:0]  vec_idx,
`ifdef VSG_CHECK_EN
    output logic [RESP_W-1:0] resp,
    input  logic [RESP_W-1:0] expected,
    output logic              mismatch
`else
    output logic [RESP_W-1:0] resp
`endif
);

    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VECTORS - 1);

    state_t            state;
    logic [VEC_W-1:0]  in_vec;
    logic              tmr_load;
    logic              tmr_en;
    logic              tmr_expire;
    logic [RESP_W-1:0] resp_cap;

    assign {in_3, in_2, in_1} = in_vec;

    assign tmr_load = ((state == IDLE) && start) || (state == SAMPLE);
    assign tmr_en   = (state == DRIVE);
    assign resp_cap = resp_insert(resp, vec_idx, {out_2, out_1});

    vsg_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tmr_load),
        .enable (tmr_en),
        .expire (tmr_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            vec_idx <= '0;
            in_vec  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            resp    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        resp    <= '0;
                        vec_idx <= '0;
                        in_vec  <= '0;
                        busy    <= 1'b1;
                        state   <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (tmr_expire) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    resp <= resp_cap;
                    if (vec_idx == LAST_VEC) begin
                        in_vec <= '0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        vec_idx <= vec_idx + VEC_W'(1);
                        in_vec  <= vec_idx + VEC_W'(1);
                        state   <= DRIVE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef VSG_CHECK_EN
    // Compare against the final capture so the flag is valid in the DONE cycle itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch <= 1'b0;
        end else if ((state == IDLE) && start) begin
            mismatch <= 1'b0;
        end else if ((state == SAMPLE) && (vec_idx == LAST_VEC)) begin
            mismatch <= (resp_cap != expected);
        end
    end
`endif

endmodule

// File: tb/tb_vector_sweep_gen.sv
// Directed bench for vector_sweep_gen: loopback sweeps at HOLD_CYCLES 1 and 3,
// ignored mid-sweep start, async reset mid-sweep, constant response and held start.
module tb_vector_sweep_gen;

    logic clk = 1'b0;
    logic rst_n;
    logic start_a, start_b;
    logic force_ones;

    logic in1_a, in2_a, in3_a, out1_a, out2_a, busy_a, done_a;
    logic [2:0]  vec_a;
    logic [15:0] resp_a;
    logic in1_b, in2_b, in3_b, out1_b, out2_b, busy_b, done_b;
    logic [2:0]  vec_b;
    logic [15:0] resp_b;
`ifdef VSG_CHECK_EN
    logic [15:0] exp_a, exp_b;
    logic        mm_a, mm_b;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign out1_a = force_ones ? 1'b1 : in1_a;
    assign out2_a = force_ones ? 1'b1 : in3_a;
    assign out1_b = in1_b;
    assign out2_b = in3_b;

    vector_sweep_gen #(.HOLD_CYCLES(1)) u_dut_h1 (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .in_1(in1_a), .in_2(in2_a), .in_3(in3_a),
        .out_1(out1_a), .out_2(out2_a),
        .busy(busy_a), .done(done_a), .vec_idx(vec_a),
`ifdef VSG_CHECK_EN
        .resp(resp_a), .expected(exp_a), .mismatch(mm_a)
`else
        .resp(resp_a)
`endif
    );

    vector_sweep_gen #(.HOLD_CYCLES(3)) u_dut_h3 (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .in_1(in1_b), .in_2(in2_b), .in_3(in3_b),
        .out_1(out1_b), .out_2(out2_b),
        .busy(busy_b), .done(done_b), .vec_idx(vec_b),
`ifdef VSG_CHECK_EN
        .resp(resp_b), .expected(exp_b), .mismatch(mm_b)
`else
        .resp(resp_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start, follow the sweep cycle by cycle, then check the done cycle and the one after.
    task automatic sweep(input bit h3, input int hold, input logic [15:0] exp_resp,
                         input bit repulse, input bit exp_mm, input string tag);
        int n;
        int lim;
        bit seen;
        bit pulsed;
        logic [2:0] want;
        if (h3) start_b = 1'b1; else start_a = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        n = 0;
        seen = 1'b0;
        pulsed = 1'b0;
        lim = 8 * (hold + 1) + 20;
        while (!seen && n < lim) begin
            if (h3 ? done_b : done_a) begin
                seen = 1'b1;
            end else begin
                want = 3'(n / (hold + 1));
                check({tag, "_vec"}, h3 ? vec_b : vec_a, want);
                check({tag, "_in"}, h3 ? {in3_b, in2_b, in1_b} : {in3_a, in2_a, in1_a}, want);
                check({tag, "_busy"}, h3 ? busy_b : busy_a, 1'b1);
                if (repulse && !pulsed && vec_a == 3'd3) begin
                    start_a = 1'b1;
                    pulsed = 1'b1;
                end else begin
                    start_a = 1'b0;
                end
                tick();
                n++;
            end
        end
        start_a = 1'b0;
        check({tag, "_cycles"}, n, 8 * (hold + 1));
        check({tag, "_resp"}, h3 ? resp_b : resp_a, exp_resp);
        check({tag, "_done_busy"}, h3 ? busy_b : busy_a, 1'b0);
        check({tag, "_done_in"}, h3 ? {in3_b, in2_b, in1_b} : {in3_a, in2_a, in1_a}, 3'd0);
`ifdef VSG_CHECK_EN
        check({tag, "_mismatch"}, h3 ? mm_b : mm_a, exp_mm);
`else
        check({tag, "_mm_unused"}, exp_mm, 1'b0);
`endif
        tick();
        check({tag, "_done_pulse"}, h3 ? done_b : done_a, 1'b0);
        check({tag, "_resp_hold"}, h3 ? resp_b : resp_a, exp_resp);
        check({tag, "_idle_in"}, h3 ? {in3_b, in2_b, in1_b} : {in3_a, in2_a, in1_a}, 3'd0);
    endtask

    task automatic wait_done_a(input string tag);
        int n;
        n = 0;
        while (!done_a && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_seen"}, done_a, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int n;
        int extra;
        bit found;
        rst_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        force_ones = 1'b0;
`ifdef VSG_CHECK_EN
        exp_a = 16'hEE44;
        exp_b = 16'hEE44;
`endif
        repeat (3) tick();
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_vec", vec_a, 3'd0);
        check("rst_in", {in3_a, in2_a, in1_a}, 3'd0);
        check("rst_resp", resp_a, 16'h0000);
`ifdef VSG_CHECK_EN
        check("rst_mm", mm_a, 1'b0);
`endif
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_busy", busy_a, 1'b0);

        // Loopback sweeps at both hold settings.
        sweep(1'b0, 1, 16'hEE44, 1'b0, 1'b0, "h1");
        sweep(1'b1, 3, 16'hEE44, 1'b0, 1'b0, "h3");

        // Start re-pulsed at vector 3 must be ignored.
        sweep(1'b0, 1, 16'hEE44, 1'b1, 1'b0, "repulse");
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_a) extra++;
            tick();
        end
        check("repulse_extra_done", extra, 0);
        check("repulse_idle_busy", busy_a, 1'b0);

        // Asynchronous reset in the middle of vector 5.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        found = 1'b0;
        n = 0;
        while (!found && n < 40) begin
            if (vec_a == 3'd5) found = 1'b1;
            else begin
                tick();
                n++;
            end
        end
        check("midrst_reached5", found, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy_a, 1'b0);
        check("midrst_vec", vec_a, 3'd0);
        check("midrst_in", {in3_a, in2_a, in1_a}, 3'd0);
        check("midrst_resp", resp_a, 16'h0000);
        check("midrst_done", done_a, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        sweep(1'b0, 1, 16'hEE44, 1'b0, 1'b0, "postrst");

        // Constant response, start held high for back-to-back sweeps.
        force_ones = 1'b1;
        start_a = 1'b1;
        tick();
        n = 0;
        while (!done_a && n < 40) begin
            tick();
            n++;
        end
        check("held_cycles", n, 16);
        check("held_resp", resp_a, 16'hFFFF);
        tick();
        check("held_gap_busy", busy_a, 1'b0);
        check("held_gap_in", {in3_a, in2_a, in1_a}, 3'd0);
        tick();
        check("held_restart_busy", busy_a, 1'b1);
        check("held_restart_vec", vec_a, 3'd0);
        check("held_restart_resp", resp_a, 16'h0000);
        start_a = 1'b0;
        wait_done_a("held_second");
        check("held_second_resp", resp_a, 16'hFFFF);
        tick();
        force_ones = 1'b0;
        tick();

`ifdef VSG_CHECK_EN
        exp_a = 16'hEE45;
        sweep(1'b0, 1, 16'hEE44, 1'b0, 1'b1, "mm");
        repeat (3) tick();
        check("mm_hold", mm_a, 1'b1);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("mm_clear_on_start", mm_a, 1'b0);
        wait_done_a("mm_second");
        tick();
        exp_a = 16'hEE44;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
